// File: rtl/mul_mac_sequencer.sv
// Drives the 8x8 shift-add multiplier one operand pair at a time and accumulates the
// products of each frame, presenting sum, pair count and overflow over valid/ready.
module mul_mac_sequencer #(
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    output logic             mul_start,
    input  logic [15:0]      mul_res,
    input  logic             mul_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [7:0]       out_count,
    output logic             out_overflow,
    output logic             err_timeout
);

    localparam int unsigned     TmrW    = $clog2(TIMEOUT + 1);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitLow,
        StWaitHigh,
        StAccum,
        StOutput,
        StError
    } state_t;

    state_t           state_q;
    logic [7:0]       mul_a_q;
    logic [7:0]       mul_b_q;
    logic             mul_start_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             err_q;
    logic             last_q;
    logic             ovf_q;
    logic [ACC_W-1:0] acc_q;
    logic [7:0]       count_q;
    logic [TmrW-1:0]  tmr_q;

    logic [ACC_W:0]   sum;
    logic [7:0]       count_inc;

    // Extra top bit of the sum captures the carry out of the accumulator.
    assign sum       = {1'b0, acc_q} + (ACC_W + 1)'(mul_res);
    assign count_inc = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            last_q      <= 1'b0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            tmr_q       <= '0;
        end else begin
            mul_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        mul_a_q     <= in_a;
                        mul_b_q     <= in_b;
                        last_q      <= in_last;
                        in_ready_q  <= 1'b0;
                        mul_start_q <= 1'b1;
                        state_q     <= StStart;
                    end
                end
                StStart: begin
                    state_q <= StWaitLow;
                end
                StWaitLow: begin
                    // A multiplier still reporting ready here never saw the start pulse.
                    if (!mul_ready) begin
                        tmr_q   <= '0;
                        state_q <= StWaitHigh;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= StError;
                    end
                end
                StWaitHigh: begin
                    if (mul_ready) begin
                        state_q <= StAccum;
                    end else if (tmr_q == TmrLast) begin
                        err_q   <= 1'b1;
                        state_q <= StError;
                    end else begin
                        tmr_q <= tmr_q + TmrW'(1);
                    end
                end
                StAccum: begin
                    acc_q   <= sum[ACC_W-1:0];
                    ovf_q   <= ovf_q | sum[ACC_W];
                    count_q <= count_inc;
                    if (last_q) begin
                        out_valid_q <= 1'b1;
                        state_q     <= StOutput;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                StOutput: begin
                    if (out_ready) begin
                        acc_q       <= '0;
                        count_q     <= '0;
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                StError: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    err_q       <= 1'b1;
                end
                default: begin
                    state_q <= StError;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign mul_start    = mul_start_q;
    assign out_valid    = out_valid_q;
    assign out_acc      = acc_q;
    assign out_count    = count_q;
    assign out_overflow = ovf_q;
    assign err_timeout  = err_q;

endmodule
